// File: rtl/mux_4x1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_4x1
//  Purpose  : 4-to-1 multiplexer built as a structural tree of 2:1 stages,
//             with an optional output register and valid flag.
//  Ports    : clk       - system clock, rising-edge active
//             rst_n     - asynchronous active-low reset
//             a         - four packed data lanes, MSB lane (L0) first
//             s         - lane select, s[1] is the MSB
//             in_valid  - qualifies a/s for capture
//             y         - selected lane
//             out_valid - y holds a freshly captured selection
//  Revision : 1.0 - initial release
// ============================================================================
module mux_4x1 #(
   parameter int WIDTH        = 1,
   parameter bit REGISTER_OUT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4*WIDTH-1:0]   a,
   input  logic [1:0]           s,
   input  logic                 in_valid,
   output logic [WIDTH-1:0]     y,
   output logic                 out_valid
);

   // Lane extraction: L0 sits in the most significant slice of a.
   logic [WIDTH-1:0] w_l0;
   logic [WIDTH-1:0] w_l1;
   logic [WIDTH-1:0] w_l2;
   logic [WIDTH-1:0] w_l3;

   assign w_l0 = a[4*WIDTH-1:3*WIDTH];
   assign w_l1 = a[3*WIDTH-1:2*WIDTH];
   assign w_l2 = a[2*WIDTH-1:WIDTH];
   assign w_l3 = a[WIDTH-1:0];

   // Stage 1: two 2:1 muxes steered by s[0].
   logic [WIDTH-1:0] w_m_hi;
   logic [WIDTH-1:0] w_m_lo;

   assign w_m_hi = s[0] ? w_l1 : w_l0;
   assign w_m_lo = s[0] ? w_l3 : w_l2;

   // Stage 2: final 2:1 mux steered by s[1]. Only the chosen path reaches
   // w_sel, so unknowns on unselected lanes never leak through.
   logic [WIDTH-1:0] w_sel;

   assign w_sel = s[1] ? w_m_lo : w_m_hi;

   generate
      if (REGISTER_OUT) begin : g_reg
         logic [WIDTH-1:0] r_y;
         logic             r_out_valid;

         // y only updates on a qualified capture; out_valid is a one-cycle
         // pulse per capture, so it drops whenever in_valid is low.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_y         <= '0;
               r_out_valid <= 1'b0;
            end else begin
               r_out_valid <= in_valid;
               if (in_valid) begin
                  r_y <= w_sel;
               end
            end
         end

         assign y         = r_y;
         assign out_valid = r_out_valid;
      end else begin : g_comb
         assign y         = w_sel;
         assign out_valid = in_valid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_4x1
//  Purpose  : Directed self-checking bench for mux_4x1 covering the
//             registered 1-bit, registered 8-bit and combinational 1-bit
//             configurations.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4x1;

   logic clk;
   logic rst_n;

   // Registered, WIDTH=1
   logic [3:0]  a1;
   logic [1:0]  s1;
   logic        v1;
   logic [0:0]  y1;
   logic        ov1;

   // Registered, WIDTH=8
   logic [31:0] a8;
   logic [1:0]  s8;
   logic        v8;
   logic [7:0]  y8;
   logic        ov8;

   // Combinational, WIDTH=1
   logic [3:0]  ac;
   logic [1:0]  sc;
   logic        vc;
   logic [0:0]  yc;
   logic        ovc;

   int n_checks;
   int n_pass;

   mux_4x1 #(.WIDTH(1), .REGISTER_OUT(1'b1)) u_dut_r1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a1),
      .s         (s1),
      .in_valid  (v1),
      .y         (y1),
      .out_valid (ov1)
   );

   mux_4x1 #(.WIDTH(8), .REGISTER_OUT(1'b1)) u_dut_r8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a8),
      .s         (s8),
      .in_valid  (v8),
      .y         (y8),
      .out_valid (ov8)
   );

   mux_4x1 #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_dut_c1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (ac),
      .s         (sc),
      .in_valid  (vc),
      .y         (yc),
      .out_valid (ovc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive the 1-bit registered DUT at a negedge, then sample at the next
   // negedge (one rising edge later).
   task automatic step1(input logic [3:0] a, input logic [1:0] s, input logic v);
      a1 = a;
      s1 = s;
      v1 = v;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0]  av;
      logic [1:0]  sv;
      logic [31:0] lanes;
      logic [7:0]  exp8 [4];

      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0;
      a1 = '0; s1 = '0; v1 = 1'b0;
      a8 = '0; s8 = '0; v8 = 1'b0;
      ac = '0; sc = '0; vc = 1'b0;

      @(negedge clk);
      @(negedge clk);
      check("reset_y1",   32'(y1),  32'h0);
      check("reset_ov1",  32'(ov1), 32'h0);
      check("reset_y8",   32'(y8),  32'h0);
      check("reset_ov8",  32'(ov8), 32'h0);
      rst_n = 1'b1;

      // One-hot lane walk: each lane in turn carries the only 1.
      step1(4'b1000, 2'b00, 1'b1);
      check("l0_y",  32'(y1),  32'h1);
      check("l0_ov", 32'(ov1), 32'h1);
      step1(4'b0100, 2'b01, 1'b1);
      check("l1_y",  32'(y1),  32'h1);
      check("l1_ov", 32'(ov1), 32'h1);
      step1(4'b0010, 2'b10, 1'b1);
      check("l2_y",  32'(y1),  32'h1);
      check("l2_ov", 32'(ov1), 32'h1);
      step1(4'b0001, 2'b11, 1'b1);
      check("l3_y",  32'(y1),  32'h1);
      check("l3_ov", 32'(ov1), 32'h1);

      // Ones on unselected lanes must not leak into y.
      step1(4'b0111, 2'b00, 1'b1);
      check("noleak_y", 32'(y1), 32'h0);

      // Hold behaviour with in_valid low.
      step1(4'b1000, 2'b00, 1'b1);
      check("cap_y", 32'(y1), 32'h1);
      step1(4'b0000, 2'b01, 1'b0);
      check("hold_y",  32'(y1),  32'h1);
      check("hold_ov", 32'(ov1), 32'h0);
      step1(4'b0000, 2'b01, 1'b1);
      check("recap_y",  32'(y1),  32'h0);
      check("recap_ov", 32'(ov1), 32'h1);

      // Asynchronous reset between edges.
      step1(4'b1000, 2'b00, 1'b1);
      check("pre_rst_y", 32'(y1), 32'h1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_y",  32'(y1),  32'h0);
      check("async_rst_ov", 32'(ov1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step1(4'b1000, 2'b00, 1'b1);
      check("post_rst_y",  32'(y1),  32'h1);
      check("post_rst_ov", 32'(ov1), 32'h1);
      v1 = 1'b0;

      // 8-bit lanes stepped through every select.
      exp8[0] = 8'hA1;
      exp8[1] = 8'hB2;
      exp8[2] = 8'hC3;
      exp8[3] = 8'hD4;
      a8 = 32'hA1B2C3D4;
      v8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s8 = 2'(i);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("w8_s%0d_y", i), 32'(y8), 32'(exp8[i]));
         check($sformatf("w8_s%0d_ov", i), 32'(ov8), 32'h1);
      end
      v8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("w8_idle_ov", 32'(ov8), 32'h0);
      check("w8_idle_y",  32'(y8),  32'hD4);

      // Combinational sweep; rst_n toggles too and must have no effect.
      for (int i = 0; i < 64; i++) begin
         av = i[5:2];
         sv = i[1:0];
         ac = av;
         sc = sv;
         vc = i[0] ^ i[3];
         rst_n = i[4];
         #1;
         check($sformatf("comb_a%h_s%0d_y", av, sv), 32'(yc), 32'(av[3 - sv]));
         check($sformatf("comb_a%h_s%0d_ov", av, sv), 32'(ovc), 32'(i[0] ^ i[3]));
      end
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- Registered 4-to-1 multiplexer built as a tree of 2-to-1 mux stages.
- First stage: two 2:1 muxes selected by s[0]. Second stage: one 2:1 mux selected by s[1].
- Selects one of four data lanes packed MSB-first on a single input bus.
- Used as a generic selection primitive in datapaths. Provides a registered output with a valid flag, or a pure combinational output when configured.

Parameters:
- WIDTH, 1, bit width of each data lane and of y.
- REGISTER_OUT, 1, 1 = output registered (latency 1 cycle); 0 = combinational output (clk/rst_n unused by data path).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  4*WIDTH  packed data lanes, MSB lane first (see Behaviour).
- s  input  2  lane select; s[1] is the MSB.
- in_valid  input  1  qualifies a/s for capture.
- y  output  WIDTH  selected lane.
- out_valid  output  1  y holds a freshly captured selection.

Behaviour:
- Lane mapping (MSB-first):
  - L0 = a[4W-1:3W], selected by s=00.
  - L1 = a[3W-1:2W], selected by s=01.
  - L2 = a[2W-1:W], selected by s=10.
  - L3 = a[W-1:0], selected by s=11.
  - For WIDTH=1 this means y = a[3-s].
- Structure:
  - Stage 1: m_hi = s[0] ? L1 : L0; m_lo = s[0] ? L3 : L2.
  - Stage 2: sel = s[1] ? m_lo : m_hi.
  - The implementation must be the structural 2:1 tree. No priority logic.
- REGISTER_OUT=1:
  - While rst_n=0 (asynchronous, no clock needed): y=0, out_valid=0.
  - On a rising clk edge with in_valid=1: y <= sel and out_valid <= 1.
  - On a rising clk edge with in_valid=0: y holds its previous value and out_valid <= 0.
  - Latency is exactly 1 cycle from sampled a/s/in_valid to y/out_valid.
  - Reset asserted mid-stream clears y and out_valid immediately.
  - After rst_n deasserts, the first capture occurs on the first rising edge with in_valid=1.
- REGISTER_OUT=0:
  - y = sel combinationally; out_valid = in_valid.
  - rst_n and clk have no effect on the outputs.
- Every value of s is legal; there is no undefined select.
- Changes to the non-selected lanes must not affect y.
- X on the selected lane propagates to y. X on the other lanes does not.

Test Plan:
- WIDTH=1, REGISTER_OUT=1, in_valid=1:
  - a=1000, s=00 -> y=1 next edge.
  - a=0100, s=01 -> y=1.
  - a=0010, s=10 -> y=1.
  - a=0001, s=11 -> y=1.
  - out_valid=1 throughout.
- a=0111, s=00 -> y=0: only L0 is chosen, so the ones on the other lanes must not leak.
- in_valid=0 after capturing y=1: change a=0000, s=01 -> y stays 1, out_valid=0. Then in_valid=1 -> y=0 next edge.
- Reset mid-operation: with y=1, drive rst_n=0 between clock edges -> y=0 and out_valid=0 immediately, without waiting for an edge.
  - After release with a=1000, s=00, in_valid=1 -> y=1 one edge later.
- WIDTH=8, a=0xA1B2C3D4, stepping s through 00, 01, 10, 11 -> y = 0xA1, 0xB2, 0xC3, 0xD4 on successive cycles.
- REGISTER_OUT=0, WIDTH=1: sweep all 64 (a,s) combinations -> y = a[3-s] with zero cycle delay, and out_valid follows in_valid.
